// File: rtl/stim_driver_06.sv
// Stimulus driver: issues numbered operand pairs to a downstream start/result/check
// interface, scores each transaction as pass or fail, and guards every wait with a watchdog.
module stim_driver_06 #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned TMO   = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN_go,
    input  logic [15:0]      go_count,
    output logic             RDY_go,
    output logic [WIDTH-1:0] start_a,
    output logic [WIDTH-1:0] start_b,
    output logic             EN_start,
    input  logic             RDY_start,
    input  logic [WIDTH-1:0] res_result,
    input  logic             RDY_result,
    output logic             EN_check,
    input  logic [WIDTH-1:0] ch_result,
    input  logic             RDY_check,
    output logic             done,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic             timeout
);

    localparam int unsigned WD_W = (TMO < 2) ? 1 : $clog2(TMO);

    // Alternating 1010...10 mask; bit 0 is clear.
    function automatic logic [WIDTH-1:0] alt_pat();
        logic [WIDTH-1:0] p;
        for (int i = 0; i < int'(WIDTH); i++) begin
            p[i] = i[0];
        end
        return p;
    endfunction

    localparam logic [WIDTH-1:0] ALT = alt_pat();

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] seq;
    logic [15:0]      remaining;
    logic [WD_W-1:0]  wd;

    logic go_acc, start_acc, txn_end, hit, miss, tmo_hit, wd_inc;

    assign start_a = seq;
    assign start_b = seq ^ ALT;
    assign RDY_go  = (state == IDLE) || (state == DONE);
    assign done    = (state == DONE);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, handshake strobes and datapath controls
    always_comb begin
        state_d   = state;
        EN_start  = 1'b0;
        EN_check  = 1'b0;
        go_acc    = 1'b0;
        start_acc = 1'b0;
        txn_end   = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        tmo_hit   = 1'b0;
        wd_inc    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (EN_go) begin
                    go_acc  = 1'b1;
                    state_d = (go_count != 16'd0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                EN_start = RDY_start;
                if (RDY_start) begin
                    start_acc = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (RDY_result && RDY_check) begin
                    EN_check = 1'b1;
                    txn_end  = 1'b1;
                    hit      = (res_result == ch_result);
                    miss     = (res_result != ch_result);
                end else if (wd == WD_W'(TMO - 1)) begin
                    tmo_hit = 1'b1;
                    txn_end = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
                if (txn_end) begin
                    state_d = (remaining == 16'd1) ? DONE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Run datapath: sequence, remaining count, watchdog and scoreboard counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seq        <= '0;
            remaining  <= 16'd0;
            wd         <= '0;
            pass_count <= 16'd0;
            fail_count <= 16'd0;
            timeout    <= 1'b0;
        end else begin
            if (go_acc) begin
                remaining  <= go_count;
                seq        <= '0;
                pass_count <= 16'd0;
                fail_count <= 16'd0;
                timeout    <= 1'b0;
            end
            if (start_acc) begin
                wd <= '0;
            end else if (wd_inc) begin
                wd <= wd + WD_W'(1);
            end
            if (hit) begin
                pass_count <= pass_count + 16'd1;
            end
            if (miss || tmo_hit) begin
                fail_count <= fail_count + 16'd1;
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end
            if (txn_end) begin
                remaining <= remaining - 16'd1;
                if (remaining != 16'd1) begin
                    seq <= seq + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stim_driver_06.sv
// Self-checking bench for stim_driver_06: table of runs plus hand-written corner sequences,
// with an operand scoreboard that is popped on every EN_start.
module tb_stim_driver_06;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned TMO   = 20;
    localparam logic [WIDTH-1:0] ALT = 10'h2AA;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN_go;
    logic [15:0]      go_count;
    logic             RDY_go;
    logic [WIDTH-1:0] start_a, start_b;
    logic             EN_start;
    logic [WIDTH-1:0] res_v, ch_v;
    logic             EN_check;
    logic             done;
    logic [15:0]      pass_count, fail_count;
    logic             timeout;

    logic       start_rdy, res_rdy;
    logic [7:0] mask;

    // Downstream model: result is a function of the operands; check differs when mask flags that txn.
    assign res_v = start_a + start_b;
    assign ch_v  = res_v ^ WIDTH'(mask[start_a[2:0]]);

    stim_driver_06 #(.WIDTH(WIDTH), .TMO(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN_go      (EN_go),
        .go_count   (go_count),
        .RDY_go     (RDY_go),
        .start_a    (start_a),
        .start_b    (start_b),
        .EN_start   (EN_start),
        .RDY_start  (start_rdy),
        .res_result (res_v),
        .RDY_result (res_rdy),
        .EN_check   (EN_check),
        .ch_result  (ch_v),
        .RDY_check  (res_rdy),
        .done       (done),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .timeout    (timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] cnt;
        logic [7:0]  mask;
        int          exp_pass;
        int          exp_fail;
    } vec_t;

    vec_t             vt[4];
    logic [2*WIDTH-1:0] expq[$];
    int checks = 0;
    int passed = 0;
    int n_start = 0;
    int n_check = 0;
    int cyc = 0;
    int last_start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: each EN_start must match the next queued operand pair.
    always @(negedge CLK) begin
        logic [2*WIDTH-1:0] e;
        #1;
        cyc++;
        if (!RST) begin
            if (EN_start) begin
                n_start++;
                last_start_cyc = cyc;
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_start: got EN_start with seq %0h, expected none", start_a);
                end else begin
                    e = expq.pop_front();
                    chk("start_a", 32'(start_a), 32'(e[2*WIDTH-1:WIDTH]));
                    chk("start_b", 32'(start_b), 32'(e[WIDTH-1:0]));
                end
            end
            if (EN_check) begin
                n_check++;
                chk("start_check_exclusive", 32'(EN_start), 32'd0);
                chk("check_latency_ge1", 32'((cyc - last_start_cyc) >= 1), 32'd1);
            end
        end
    end

    task automatic push_ops(input int n);
        logic [WIDTH-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = WIDTH'(i);
            expq.push_back({a, a ^ ALT});
        end
    endtask

    task automatic run_go(input logic [15:0] n);
        EN_go    = 1'b1;
        go_count = n;
        @(negedge CLK);
        EN_go    = 1'b0;
        go_count = 16'd0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            @(negedge CLK);
            k++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy_go"},   32'(RDY_go),     32'd1);
        chk({tag, "_done"},     32'(done),       32'd0);
        chk({tag, "_en_start"}, 32'(EN_start),   32'd0);
        chk({tag, "_en_check"}, 32'(EN_check),   32'd0);
        chk({tag, "_pass"},     32'(pass_count), 32'd0);
        chk({tag, "_fail"},     32'(fail_count), 32'd0);
        chk({tag, "_timeout"},  32'(timeout),    32'd0);
        chk({tag, "_start_a"},  32'(start_a),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int n, s0, c0;
        vt[0] = '{cnt: 16'd3, mask: 8'h00, exp_pass: 3, exp_fail: 0};
        vt[1] = '{cnt: 16'd2, mask: 8'h02, exp_pass: 1, exp_fail: 1};
        vt[2] = '{cnt: 16'd4, mask: 8'h05, exp_pass: 2, exp_fail: 2};
        vt[3] = '{cnt: 16'd5, mask: 8'h1F, exp_pass: 0, exp_fail: 5};

        RST = 1'b1; EN_go = 1'b0; go_count = 16'd0;
        start_rdy = 1'b1; res_rdy = 1'b1; mask = 8'h00;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("por");
        RST = 1'b0;
        @(negedge CLK);

        // Table-driven runs with an always-ready downstream
        for (int v = 0; v < 4; v++) begin
            mask = vt[v].mask;
            push_ops(int'(vt[v].cnt));
            run_go(vt[v].cnt);
            chk("run_busy_done_low", 32'(done), 32'd0);
            wait_done(200);
            chk("run_pass", 32'(pass_count), 32'(vt[v].exp_pass));
            chk("run_fail", 32'(fail_count), 32'(vt[v].exp_fail));
            chk("run_timeout", 32'(timeout), 32'd0);
            chk("run_rdy_go", 32'(RDY_go), 32'd1);
            chk("run_ops_consumed", 32'(expq.size()), 32'd0);
            @(negedge CLK);
        end
        mask = 8'h00;

        // Result never valid: watchdog expiry
        res_rdy = 1'b0;
        c0 = n_check;
        push_ops(1);
        run_go(16'd1);
        for (int k = 0; k < 50 && !EN_start; k++) @(negedge CLK);
        n = 0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(TMO + 1));
        chk("tmo_pass", 32'(pass_count), 32'd0);
        chk("tmo_fail", 32'(fail_count), 32'd1);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_no_check", 32'(n_check - c0), 32'd0);
        @(negedge CLK);
        res_rdy = 1'b1;

        // Zero-length run clears the sticky timeout and lands in DONE at once
        run_go(16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_pass", 32'(pass_count), 32'd0);
        chk("zero_fail", 32'(fail_count), 32'd0);
        chk("zero_timeout", 32'(timeout), 32'd0);
        @(negedge CLK);

        // Downstream not ready for 20 cycles; an EN_go arriving mid-run is ignored
        start_rdy = 1'b0;
        s0 = n_start;
        push_ops(1);
        run_go(16'd1);
        repeat (10) @(negedge CLK);
        run_go(16'd7);
        repeat (9) @(negedge CLK);
        chk("stall_no_start", 32'(n_start - s0), 32'd0);
        chk("stall_no_timeout", 32'(timeout), 32'd0);
        chk("stall_not_done", 32'(done), 32'd0);
        start_rdy = 1'b1;
        wait_done(50);
        chk("stall_pass", 32'(pass_count), 32'd1);
        chk("stall_fail", 32'(fail_count), 32'd0);
        chk("stall_timeout", 32'(timeout), 32'd0);
        chk("stall_one_start", 32'(n_start - s0), 32'd1);
        @(negedge CLK);

        // Reset pulse in the middle of a 5-transaction run
        res_rdy = 1'b0;
        push_ops(5);
        run_go(16'd5);
        n = 0;
        while (fail_count != 16'd1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_first_timeout", 32'(fail_count), 32'd1);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        expq.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        res_rdy = 1'b1;
        push_ops(1);
        run_go(16'd1);
        wait_done(50);
        chk("restart_pass", 32'(pass_count), 32'd1);
        chk("restart_fail", 32'(fail_count), 32'd0);
        chk("restart_ops_consumed", 32'(expq.size()), 32'd0);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stim_driver_06.md
STIM_DRIVER_06 -- requirements
Module: stim_driver_06

Interface
REQ-001 SHALL have parameter WIDTH, default 10, data width of start_a, start_b, res$result and ch$result.
REQ-002 SHALL have parameter TMO, default 255, watchdog limit in cycles for the WAIT state.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 EN_go  input  1  start a run; accepted only when RDY_go=1.
REQ-006 go_count  input  16  number of transactions in the run, sampled with EN_go.
REQ-007 RDY_go  output  1  high in IDLE and DONE.
REQ-008 start_a  output  WIDTH  operand a to the downstream design.
REQ-009 start_b  output  WIDTH  operand b to the downstream design.
REQ-010 EN_start  output  1  fire start method.
REQ-011 RDY_start  input  1  downstream ready for start.
REQ-012 res$result  input  WIDTH  downstream result value.
REQ-013 RDY_result  input  1  result valid.
REQ-014 EN_check  output  1  fire check method (consumes result).
REQ-015 ch$result  input  WIDTH  downstream check value.
REQ-016 RDY_check  input  1  check valid.
REQ-017 done  output  1  run complete.
REQ-018 pass_count  output  16  transactions where res$result equaled ch$result.
REQ-019 fail_count  output  16  mismatched or timed-out transactions.
REQ-020 timeout  output  1  sticky; at least one watchdog expiry this run.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE/DONE: EN_go with go_count!=0 SHALL load remaining=go_count, clear seq, pass_count, fail_count and timeout, and go to ISSUE.
REQ-023 IDLE/DONE: EN_go with go_count=0 SHALL clear the counters and go to DONE with no EN_start.
REQ-024 SHALL ignore EN_go outside IDLE/DONE; ignored requests SHALL not affect any state.
REQ-025 start_a SHALL equal seq[WIDTH-1:0].
REQ-026 start_b SHALL equal seq XOR the alternating pattern 0b1010…10 (10'h2AA at default width).
REQ-027 Both operands SHALL be combinational from seq, held stable across ISSUE and WAIT.
REQ-028 ISSUE: EN_start SHALL equal RDY_start; on the cycle RDY_start=1, SHALL go to WAIT and clear the watchdog; otherwise SHALL stay in ISSUE with no watchdog.
REQ-029 WAIT: when RDY_result=1 and RDY_check=1, SHALL assert EN_check for exactly that cycle.
REQ-030 On that EN_check cycle, SHALL compare res$result with ch$result: equal increments pass_count, unequal increments fail_count.
REQ-031 WAIT: watchdog SHALL increment each cycle without both readies.
REQ-032 WAIT: on the cycle the watchdog reaches TMO, SHALL increment fail_count, set timeout, and assert no EN_check.
REQ-033 Completion or timeout of a transaction SHALL decrement remaining.
REQ-034 Completion or timeout: if remaining was 1, SHALL go to DONE; otherwise seq SHALL increment (wrapping 2^WIDTH-1 to 0) and the FSM SHALL return to ISSUE.
REQ-035 Per transaction SHALL hold the 1-cycle minimum handshake latency: start accepted at cycle N, EN_check no earlier than N+1.
REQ-036 done SHALL be 1 only in DONE; counters and timeout SHALL hold in DONE until the next accepted EN_go.
REQ-037 EN_start and EN_check SHALL never be asserted in the same cycle.
REQ-038 pass_count+fail_count SHALL equal go_count at DONE.

Reset
REQ-039 RST=1 SHALL immediately force IDLE, seq=0, remaining=0, watchdog=0, and pass_count=fail_count=0.
REQ-040 RST=1 SHALL immediately force timeout=0, done=0, EN_start=0, EN_check=0, RDY_go=1.
REQ-041 RST asserted mid-run SHALL abort the run with no further EN_start/EN_check.

Verification
REQ-042 go_count=3, downstream always ready with equal result/check -> operands (0,2AA),(1,2AB),(2,2A8); pass=3, fail=0, done=1.
REQ-043 go_count=2, second check value differs from result -> pass=1, fail=1, timeout=0.
REQ-044 go_count=1, RDY_result never asserted -> EN_check never fires; fail=1, timeout=1, done at TMO cycles after start.
REQ-045 RDY_start held low 20 cycles -> EN_start stays 0, no timeout; then proceeds normally to pass=1.
REQ-046 go_count=0 -> DONE next cycle, counters 0, no EN_start.
REQ-047 RST pulse during WAIT of a 5-transaction run -> all outputs at reset values; a new EN_go restarts at seq=0.
